// File: rtl/sa_tile_sched.sv
// Tile scheduler for a weight-stationary systolic array: per weight tile it
// loads SYSTOLIC_WIDTH weight rows, flushes the transposer, streams A rows,
// then drains PIPE_LAT cycles of results into sp_2.
// Ports: clk, rst_n (async, active-high); job inputs start/abort/rows/tiles/
// a_base/w_base/o_base/hash_ready; read port rd_en/rd_sel/rd_addr; write port
// wr_en/wr_addr; systolic and transposer controls; busy/done/state_o status.
module sa_tile_sched #(
    parameter int SYSTOLIC_WIDTH = 4,
    parameter int PIPE_LAT       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] rows,
    input  logic [15:0] tiles,
    input  logic [31:0] a_base,
    input  logic [31:0] w_base,
    input  logic [31:0] o_base,
    input  logic        hash_ready,
    output logic        rd_en,
    output logic        rd_sel,
    output logic [31:0] rd_addr,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic        sys_enable,
    output logic        sys_state,
    output logic        sys_mode,
    output logic        trans_select,
    output logic        trans_rst_sync,
    output logic        busy,
    output logic        done,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_FREE     = 4'd0,
        S_LOADW1   = 4'd4,
        S_LOADW2   = 4'd5,
        S_CALC     = 4'd6,
        S_WAITHASH = 4'd7,
        S_DRAIN    = 4'd8
    } state_t;

    localparam logic [15:0] SW_LAST = 16'(SYSTOLIC_WIDTH - 1);
    localparam logic [15:0] PL_LAST = 16'(PIPE_LAT - 1);
    localparam logic [31:0] SW_STEP = 32'(SYSTOLIC_WIDTH);

    state_t              r_state;
    logic [15:0]         r_cnt;
    logic [15:0]         r_tcnt;
    logic [15:0]         r_tile;
    logic [15:0]         r_rows;
    logic [15:0]         r_tiles;
    logic [31:0]         r_abase;
    logic [31:0]         r_wnext;
    logic [31:0]         r_rd_addr;
    logic [31:0]         r_wr_addr;
    logic [PIPE_LAT-1:0] r_pipe;
    logic                r_rd_en;
    logic                r_rd_sel;
    logic                r_sys_en;
    logic                r_sys_state;
    logic                r_trans_sel;
    logic                r_trans_rst;
    logic                r_busy;
    logic                r_done;
    logic                w_calc_rd;

    // Only A-row reads produce a result that must be written back.
    assign w_calc_rd = r_rd_en & r_rd_sel;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= S_FREE;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_tile      <= '0;
            r_rows      <= '0;
            r_tiles     <= '0;
            r_abase     <= '0;
            r_wnext     <= '0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_pipe      <= '0;
            r_rd_en     <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_sys_en    <= 1'b0;
            r_sys_state <= 1'b0;
            r_trans_sel <= 1'b0;
            r_trans_rst <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_pipe[0] <= w_calc_rd;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            // Output address advances after each write; across tiles this
            // yields o_base + t*rows + n without a multiplier.
            if (r_pipe[PIPE_LAT-1]) begin
                r_wr_addr <= r_wr_addr + 32'd1;
            end
            if (abort) begin
                r_state     <= S_FREE;
                r_pipe      <= '0;
                r_rd_en     <= 1'b0;
                r_rd_sel    <= 1'b0;
                r_rd_addr   <= '0;
                r_sys_en    <= 1'b0;
                r_sys_state <= 1'b0;
                r_trans_sel <= 1'b0;
                r_trans_rst <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                unique case (r_state)
                    S_FREE: begin
                        if (start && rows != 16'd0 && tiles != 16'd0) begin
                            r_state     <= S_LOADW1;
                            r_rows      <= rows;
                            r_tiles     <= tiles;
                            r_abase     <= a_base;
                            r_tile      <= '0;
                            r_cnt       <= '0;
                            r_wr_addr   <= o_base;
                            r_rd_en     <= 1'b1;
                            r_rd_sel    <= 1'b0;
                            r_rd_addr   <= w_base;
                            r_wnext     <= w_base + SW_STEP;
                            r_sys_en    <= 1'b1;
                            r_sys_state <= 1'b0;
                            r_trans_sel <= 1'b0;
                            r_trans_rst <= 1'b1;
                            r_busy      <= 1'b1;
                        end else if (start) begin
                            r_done <= 1'b1;
                        end
                    end
                    S_LOADW1: begin
                        r_trans_rst <= 1'b0;
                        if (r_cnt == SW_LAST) begin
                            r_state <= S_LOADW2;
                            r_cnt   <= '0;
                            r_rd_en <= 1'b0;
                        end else begin
                            r_cnt     <= r_cnt + 16'd1;
                            r_rd_addr <= r_rd_addr + 32'd1;
                        end
                    end
                    S_LOADW2: begin
                        if (r_cnt == SW_LAST) begin
                            r_state     <= S_CALC;
                            r_cnt       <= '0;
                            r_tcnt      <= '0;
                            r_rd_en     <= 1'b1;
                            r_rd_sel    <= 1'b1;
                            r_rd_addr   <= r_abase;
                            r_sys_state <= 1'b1;
                            r_trans_sel <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_CALC: begin
                        if (r_cnt == r_rows - 16'd1) begin
                            r_state  <= S_DRAIN;
                            r_cnt    <= '0;
                            r_rd_en  <= 1'b0;
                            r_rd_sel <= 1'b0;
                        end else begin
                            r_cnt     <= r_cnt + 16'd1;
                            r_rd_addr <= r_rd_addr + 32'd1;
                            // Ping-pong the transposer every SW A rows.
                            if (r_tcnt == SW_LAST) begin
                                r_tcnt      <= '0;
                                r_trans_sel <= ~r_trans_sel;
                            end else begin
                                r_tcnt <= r_tcnt + 16'd1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (r_cnt == PL_LAST) begin
                            r_cnt       <= '0;
                            r_sys_en    <= 1'b0;
                            r_sys_state <= 1'b0;
                            if (r_tile == r_tiles - 16'd1) begin
                                r_state     <= S_FREE;
                                r_done      <= 1'b1;
                                r_busy      <= 1'b0;
                                r_trans_sel <= 1'b0;
                            end else begin
                                r_state <= S_WAITHASH;
                                r_tile  <= r_tile + 16'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_WAITHASH: begin
                        if (hash_ready) begin
                            r_state     <= S_LOADW1;
                            r_cnt       <= '0;
                            r_rd_en     <= 1'b1;
                            r_rd_sel    <= 1'b0;
                            r_rd_addr   <= r_wnext;
                            r_wnext     <= r_wnext + SW_STEP;
                            r_sys_en    <= 1'b1;
                            r_trans_sel <= 1'b0;
                            r_trans_rst <= 1'b1;
                        end
                    end
                    default: r_state <= S_FREE;
                endcase
            end
        end
    end

    assign rd_en          = r_rd_en;
    assign rd_sel         = r_rd_sel;
    assign rd_addr        = r_rd_addr;
    assign wr_en          = r_pipe[PIPE_LAT-1];
    assign wr_addr        = r_wr_addr;
    assign sys_enable     = r_sys_en;
    assign sys_state      = r_sys_state;
    assign sys_mode       = 1'b0;
    assign trans_select   = r_trans_sel;
    assign trans_rst_sync = r_trans_rst;
    assign busy           = r_busy;
    assign done           = r_done;
    assign state_o        = r_state;

endmodule

// File: tb/tb_sa_tile_sched.sv
// Directed bench for sa_tile_sched: a job table with hand-computed
// latencies plus abort, reset-in-DRAIN and start-while-busy sequences.
module tb_sa_tile_sched;

    localparam int SW = 4;
    localparam int PL = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] rows = '0;
    logic [15:0] tiles = '0;
    logic [31:0] a_base = '0;
    logic [31:0] w_base = '0;
    logic [31:0] o_base = '0;
    logic        hash_ready = 1'b1;
    logic        rd_en, rd_sel, wr_en;
    logic [31:0] rd_addr, wr_addr;
    logic        sys_enable, sys_state, sys_mode;
    logic        trans_select, trans_rst_sync, busy, done;
    logic [3:0]  state_o;

    sa_tile_sched #(.SYSTOLIC_WIDTH(SW), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rows(rows), .tiles(tiles), .a_base(a_base), .w_base(w_base),
        .o_base(o_base), .hash_ready(hash_ready),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .sys_enable(sys_enable), .sys_state(sys_state), .sys_mode(sys_mode),
        .trans_select(trans_select), .trans_rst_sync(trans_rst_sync),
        .busy(busy), .done(done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {27'd0, rd_en, rd_sel, wr_en, sys_enable, sys_state}
             | {24'd0, sys_mode, trans_select, trans_rst_sync, busy, done,
                3'd0} | rd_addr | wr_addr | {28'd0, state_o};
    endfunction

    typedef struct {
        logic [15:0] rows;
        logic [15:0] tiles;
        logic [31:0] wb;
        logic [31:0] ab;
        logic [31:0] ob;
        int          hold;
        int          exp_done;
    } job_t;

    typedef struct {
        logic [31:0] addr;
        logic        sel;
        logic        trs;
        logic        tsel;
    } rd_t;

    job_t jobs[6];

    task automatic run_job(input job_t j);
        rd_t         erd[$];
        logic [31:0] ewr[$];
        int          rdc[$];
        rd_t         e;
        int          waits;
        int          done_at;
        int          rc;
        waits   = 0;
        done_at = -1;
        if (j.rows != 0) begin
            for (int t = 0; t < int'(j.tiles); t++) begin
                for (int k = 0; k < SW; k++)
                    erd.push_back('{j.wb + 32'(t*SW + k), 1'b0,
                                    1'(k == 0), 1'b0});
                for (int r = 0; r < int'(j.rows); r++) begin
                    erd.push_back('{j.ab + 32'(r), 1'b1, 1'b0,
                                    1'((r / SW) % 2)});
                    ewr.push_back(j.ob + 32'(t*int'(j.rows) + r));
                end
            end
        end
        hash_ready = (j.hold == 0);
        rows   = j.rows;
        tiles  = j.tiles;
        w_base = j.wb;
        a_base = j.ab;
        o_base = j.ob;
        start  = 1'b1;
        for (int i = 1; i <= j.exp_done + 40 && done_at < 0; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            check("sys_mode", sys_mode, 0);
            check("busy", busy, 32'(i < j.exp_done));
            check("done", done, 32'(i == j.exp_done));
            if (rd_en) begin
                if (erd.size() == 0) begin
                    check("extra_rd", rd_addr, 32'hFFFF_FFFF);
                end else begin
                    e = erd.pop_front();
                    check("rd_addr", rd_addr, e.addr);
                    check("rd_sel", rd_sel, e.sel);
                    check("trans_rst", trans_rst_sync, e.trs);
                    check("trans_sel", trans_select, e.tsel);
                    check("sys_state", sys_state, e.sel);
                    check("sys_en", sys_enable, 1);
                    if (e.sel) rdc.push_back(i);
                end
            end else begin
                check("trans_rst_idle", trans_rst_sync, 0);
            end
            if (wr_en) begin
                if (ewr.size() == 0 || rdc.size() == 0) begin
                    check("extra_wr", wr_addr, 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", wr_addr, ewr.pop_front());
                    rc = rdc.pop_front();
                    check("wr_lat", 32'(i - rc), PL);
                end
            end
            if (j.hold > 0 && state_o == 4'd7 && !hash_ready) begin
                waits++;
                if (waits == j.hold) hash_ready = 1'b1;
            end
            if (done) done_at = i;
        end
        check("done_latency", 32'(done_at), 32'(j.exp_done));
        check("reads_left", 32'(erd.size()), 0);
        check("writes_left", 32'(ewr.size()), 0);
        if (j.hold > 0) check("wait_cycles", 32'(waits), 32'(j.hold));
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("free_after", state_o, 0);
        hash_ready = 1'b1;
    endtask

    initial begin
        jobs[0] = '{16'd8, 16'd1, 32'h100, 32'h0, 32'h200, 0, 22};
        jobs[1] = '{16'd4, 16'd3, 32'h100, 32'h40, 32'h300, 10, 63};
        jobs[2] = '{16'd1, 16'd2, 32'hFFFF_FFFE, 32'h10, 32'hFFFF_FFFF, 0, 30};
        jobs[3] = '{16'd0, 16'd5, 32'h100, 32'h0, 32'h200, 0, 1};
        jobs[4] = '{16'd3, 16'd0, 32'h100, 32'h0, 32'h200, 0, 1};
        jobs[5] = '{16'd5, 16'd1, 32'h20, 32'h30, 32'h40, 0, 19};

        repeat (2) @(negedge clk);
        check("reset_outputs", all_out(), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("idle_state", state_o, 0);

        for (int n = 0; n < 6; n++) run_job(jobs[n]);

        // Abort in the third CALC cycle.
        rows = 16'd6; tiles = 16'd2;
        w_base = 32'h500; a_base = 32'h600; o_base = 32'h700;
        start = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check("abort_pre_state", state_o, 6);
        check("abort_pre_addr", rd_addr, 32'h602);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_state", state_o, 0);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_wr", wr_en, 0);
            check("abort_no_done", done, 0);
        end
        run_job(jobs[5]);

        // Second start while busy, then reset during DRAIN.
        rows = 16'd4; tiles = 16'd2;
        w_base = 32'h800; a_base = 32'h900; o_base = 32'hA00;
        start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rows = 16'd9; a_base = 32'hBEEF;
            end
            if (i == 2) start = 1'b0;
            if (i >= 9 && i <= 12) begin
                check("busy_start_rd", rd_addr, 32'h900 + 32'(i - 9));
                check("busy_start_sel", rd_sel, 1);
            end
            if (i == 13) check("busy_start_drain", state_o, 8);
        end
        check("pre_rst_wr", wr_en, 1);
        rst_n = 1'b1;
        #1;
        check("async_rst_outputs", all_out(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_free", state_o, 0);
            check("post_rst_busy", busy, 0);
        end
        run_job(jobs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sa_tile_sched.md
SA_TILE_SCHED -- requirements
Module: sa_tile_sched

Interface
REQ-001 Parameters, one per line:
- SYSTOLIC_WIDTH, default 4: array edge and weight rows per tile.
- PIPE_LAT, default 5: cycles from a CALC read to its result at the sp_2 write port.
REQ-002 clk  in  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  Reset; asynchronous, active-high (asserted when 1).
REQ-004 start  in  1  Job request; sampled only in FREE.
REQ-005 abort  in  1  Synchronous job cancel.
REQ-006 rows  in  16  A rows per tile; latched at accepted start.
REQ-007 tiles  in  16  Weight tiles per job; latched at accepted start.
REQ-008 a_base, w_base, o_base  in  32 each  Word base addresses for A, weights and output; latched at accepted start.
REQ-009 hash_ready  in  1  Next weight tile present in the HASH buffer.
REQ-010 rd_en  out  1  Read strobe.
REQ-010a rd_sel  out  1  Read source select: 0 = weight, 1 = A.
REQ-010b rd_addr  out  32  Read word address.
REQ-011 wr_en  out  1  sp_2 write strobe.
REQ-011a wr_addr  out  32  sp_2 write word address.
REQ-012 sys_enable, sys_state, sys_mode  out  1 each  Systolic controls; sys_state 0 = load, 1 = compute.
REQ-013 trans_select, trans_rst_sync  out  1 each  Transposer ping-pong select and synchronous clear.
REQ-014 busy  out  1  Job in progress; done  out  1  One-cycle completion pulse.
REQ-015 state_o  out  4  Current state: FREE=0, LOADW1=4, LOADW2=5, CALC=6, DRAIN=8, WAITHASH=7.

Function
REQ-016 FREE: start=1 with rows!=0 and tiles!=0 -> LOADW1 next cycle; operands latched; tile counter t=0.
REQ-017 FREE: start=1 with rows=0 or tiles=0 -> done pulses the next cycle; state stays FREE; no reads or writes issued.
REQ-018 start while busy=1 is ignored; the latched operands are not modified.
REQ-019 LOADW1 (SYSTOLIC_WIDTH cycles, k=0..SW-1): rd_en=1, rd_sel=0, rd_addr=w_base+t*SW+k, sys_state=0, sys_enable=1.
REQ-020 trans_rst_sync is high only in the first LOADW1 cycle of each tile.
REQ-021 LOADW2 (SYSTOLIC_WIDTH cycles): rd_en=0; transposer flush; sys_state=0.
REQ-022 CALC (rows cycles, r=0..rows-1): rd_en=1, rd_sel=1, rd_addr=a_base+r, sys_state=1.
REQ-023 trans_select resets to 0 at each tile start and toggles after every SYSTOLIC_WIDTH CALC cycles.
REQ-024 wr_en equals the CALC-phase rd_en delayed exactly PIPE_LAT cycles.
REQ-025 wr_addr = o_base + t*rows + n, where n counts writes within the tile; the product is truncated to 32 bits and wraps modulo 2^32.
REQ-026 DRAIN lasts PIPE_LAT cycles, so the last write of a tile occurs in the final DRAIN cycle.
REQ-027 After DRAIN with t = tiles-1: done pulses in the same cycle as the FREE entry; busy falls.
REQ-028 After DRAIN otherwise: t increments and state -> WAITHASH.
REQ-029 WAITHASH: remain until hash_ready=1, then LOADW1.
REQ-029a If hash_ready is already 1 on WAITHASH entry, WAITHASH lasts exactly 1 cycle.
REQ-030 sys_mode=0 at all times (weight-stationary).
REQ-030a sys_enable=1 in every state except FREE and WAITHASH.
REQ-031 busy=1 in every state except FREE.
REQ-032 abort=1 in any state -> FREE next cycle: the write-delay pipeline is cleared, no further wr_en, no done pulse.
REQ-032a abort has priority over start and all other transitions.
REQ-033 rows up to 65535 and tiles up to 65535 are supported; row and tile counters are 16 bits wide.

Reset
REQ-034 While rst_n=1: state = FREE; all outputs = 0, including rd_addr, wr_addr, trans_select and the write-delay pipeline.
REQ-035 Reset asserted mid-job takes effect immediately (asynchronous); after release the block sits in FREE and requires a new start.

Verification
REQ-036 start, rows=8, tiles=1, w_base=0x100, a_base=0x0, o_base=0x200, hash_ready=1 -> expected response:
- reads 0x100..0x103, then 4 idle cycles;
- reads 0x0..0x7;
- 8 writes to 0x200..0x207, each PIPE_LAT cycles after its read;
- done 1 cycle, 22 cycles after start.
REQ-037 rows=4, tiles=3, hash_ready held 0 for 10 cycles after the first DRAIN -> expected response:
- state_o=7 for those 10 cycles;
- second-tile weight reads at 0x104..0x107;
- tile-3 writes to o_base+8..o_base+11;
- exactly one done pulse.
REQ-038 start with rows=0 -> done=1 for exactly 1 cycle; rd_en and wr_en stay 0; busy stays 0.
REQ-039 abort in the 3rd CALC cycle -> state_o=0 next cycle; no wr_en thereafter; no done; a new start then runs normally.
REQ-040 rst_n=1 asserted during DRAIN -> all outputs 0 without waiting for a clock edge; start while busy (second start ignored) checked in the same run.
REQ-041 rows=8 -> trans_select is 0 for CALC cycles 0-3 and 1 for cycles 4-7; trans_rst_sync is high exactly once per tile.
